// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift-command sequencer and its datapath.
//   - Command op codes (cmd_op)
//   - Datapath mode select codes (sr_s)
//   - Sequencer state enum
package shift_seq_pkg;

    // Command op codes; codes 3'b101..3'b111 are illegal.
    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    // Datapath mode select.
    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_SHR  = 2'b01; // msb_in enters bit N-1
    localparam logic [1:0] S_SHL  = 2'b10; // lsb_in enters bit 0
    localparam logic [1:0] S_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage : shift_seq_pkg

// File: rtl/shift_seq_top.sv
// Thin integration wrapper pairing shift_seq_ctrl with its univ_shift_reg.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset (shared)
//   cmd_*                        command handshake and payload
//   res_*                        result handshake and payload
//   busy                         sequencer not idle
//   reg_q                        datapath register contents (observation)
module shift_seq_top
    import shift_seq_pkg::*;
#(
    parameter  int N  = 8,
    localparam int AW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [N-1:0]  cmd_data,
    input  logic [AW-1:0] cmd_amt,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_data,
    output logic          res_err,
    output logic          busy,
    output logic [N-1:0]  reg_q
);

    logic [1:0]   sr_s;
    logic         sr_msb_in;
    logic         sr_lsb_in;
    logic [N-1:0] sr_i;

    shift_seq_ctrl #(.N(N)) u_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_amt   (cmd_amt),
        .sr_s      (sr_s),
        .sr_msb_in (sr_msb_in),
        .sr_lsb_in (sr_lsb_in),
        .sr_i      (sr_i),
        .sr_q      (reg_q),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy)
    );

    univ_shift_reg #(.N(N)) u_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_i      (sr_s),
        .msb_in_i (sr_msb_in),
        .lsb_in_i (sr_lsb_in),
        .d_i      (sr_i),
        .q_o      (reg_q)
    );

endmodule : shift_seq_top

// File: rtl/univ_shift_reg.sv
// Universal N-bit shift register: hold, shift right, shift left, parallel load.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset (register clears to 0)
//   s_i           mode select (S_HOLD / S_SHR / S_SHL / S_LOAD)
//   msb_in_i      serial input entering bit N-1 on a right shift
//   lsb_in_i      serial input entering bit 0 on a left shift
//   d_i           parallel-load word
//   q_o           register contents
module univ_shift_reg
    import shift_seq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   s_i,
    input  logic         msb_in_i,
    input  logic         lsb_in_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q;
        unique case (s_i)
            S_SHR:   q_d = {msb_in_i, q_q[N-1:1]};
            S_SHL:   q_d = {q_q[N-2:0], lsb_in_i};
            S_LOAD:  q_d = d_i;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_q <= '0;
        else          q_q <= q_d;
    end

    assign q_o = q_q;

endmodule : univ_shift_reg

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for univ_shift_reg. Accepts one shift/rotate command over
// a valid/ready handshake, parallel-loads the operand, steps the register one
// bit per clock for the effective amount and returns the register contents
// over a valid/ready result handshake.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_op, cmd_data, cmd_amt        op code, operand, shift amount
//   sr_s, sr_msb_in, sr_lsb_in, sr_i datapath mode, serial inputs, load word
//   sr_q                             datapath register contents
//   res_valid/res_ready              result handshake
//   res_data, res_err                result word, illegal-op flag
//   busy                             sequencer not in IDLE
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter  int N  = 8,
    localparam int AW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [N-1:0]  cmd_data,
    input  logic [AW-1:0] cmd_amt,
    output logic [1:0]    sr_s,
    output logic          sr_msb_in,
    output logic          sr_lsb_in,
    output logic [N-1:0]  sr_i,
    input  logic [N-1:0]  sr_q,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_data,
    output logic          res_err,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [2:0]    op_q,    op_d;
    logic [N-1:0]  data_q,  data_d;
    logic [AW-1:0] cnt_q,   cnt_d;
    logic          err_q,   err_d;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= OP_ROR);
    endfunction

    // Logical/arithmetic shifts saturate at N (everything shifted out);
    // rotates wrap modulo N, which for power-of-2 N is just the low bits.
    function automatic logic [AW-1:0] eff_amt(input logic [2:0] op,
                                              input logic [AW-1:0] amt);
        logic [AW-1:0] res;
        res = '0;
        unique case (op)
            OP_SLL, OP_SRL, OP_SRA: res = (amt > AW'(N)) ? AW'(N) : amt;
            OP_ROL, OP_ROR:         res = {1'b0, amt[AW-2:0]};
            default:                res = '0;
        endcase
        return res;
    endfunction

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        sr_s      = S_HOLD;
        sr_msb_in = 1'b0;
        sr_lsb_in = 1'b0;
        res_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    cnt_d   = eff_amt(cmd_op, cmd_amt);
                    err_d   = !op_legal(cmd_op);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sr_s    = S_LOAD;
                state_d = (cnt_q != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                unique case (op_q)
                    OP_SLL: sr_s = S_SHL;
                    OP_ROL: begin sr_s = S_SHL; sr_lsb_in = sr_q[N-1]; end
                    OP_SRL: sr_s = S_SHR;
                    OP_SRA: begin sr_s = S_SHR; sr_msb_in = sr_q[N-1]; end
                    OP_ROR: begin sr_s = S_SHR; sr_msb_in = sr_q[0];   end
                    default: sr_s = S_HOLD; // illegal ops never reach SHIFT
                endcase
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == AW'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign sr_i      = data_q;
    assign res_data  = sr_q;
    assign res_err   = (state_q == ST_DONE) && err_q;

endmodule : shift_seq_ctrl

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl driving a univ_shift_reg, with a
// shift_seq_top instance fed the same stimulus alongside.
module tb_shift_seq_ctrl;

    localparam int N  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic [2:0]    cmd_op;
    logic [N-1:0]  cmd_data;
    logic [AW-1:0] cmd_amt;
    logic          res_ready;

    logic          cmd_ready, res_valid, res_err, busy;
    logic [N-1:0]  res_data, sr_i, sr_q;
    logic [1:0]    sr_s;
    logic          sr_msb_in, sr_lsb_in;

    logic          top_cmd_ready, top_res_valid, top_res_err, top_busy;
    logic [N-1:0]  top_res_data, top_reg_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_amt(cmd_amt),
        .sr_s(sr_s), .sr_msb_in(sr_msb_in), .sr_lsb_in(sr_lsb_in),
        .sr_i(sr_i), .sr_q(sr_q),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err), .busy(busy)
    );

    univ_shift_reg #(.N(N)) u_reg (
        .clk(clk), .reset_n(reset_n), .s_i(sr_s),
        .msb_in_i(sr_msb_in), .lsb_in_i(sr_lsb_in), .d_i(sr_i), .q_o(sr_q)
    );

    shift_seq_top #(.N(N)) u_top (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(top_cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_amt(cmd_amt),
        .res_valid(top_res_valid), .res_ready(res_ready),
        .res_data(top_res_data), .res_err(top_res_err),
        .busy(top_busy), .reg_q(top_reg_q)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: result word, error flag and number of register steps,
    // computed directly from the op semantics.
    function automatic void model(input logic [2:0] op, input logic [7:0] d,
                                  input logic [3:0] a, output logic [7:0] r,
                                  output logic e, output int sh);
        logic [15:0] w;
        w  = {d, d};
        e  = 1'b0;
        sh = 0;
        r  = d;
        case (op)
            3'd0: begin sh = (a > 8) ? 8 : int'(a); r = d >> 0 << sh; end
            3'd1: begin sh = (a > 8) ? 8 : int'(a); r = d >> sh; end
            3'd2: begin sh = (a > 8) ? 8 : int'(a); r = 8'($signed(d) >>> sh); end
            3'd3: begin sh = int'(a) % 8; w = w << sh; r = w[15:8]; end
            3'd4: begin sh = int'(a) % 8; w = w >> sh; r = w[7:0]; end
            default: begin e = 1'b1; sh = 0; r = d; end
        endcase
    endfunction

    // Issue one command, follow it to its result, hold the result for
    // 'hold' cycles with res_ready low, then consume it.
    task automatic do_cmd(input string tag, input logic [2:0] op,
                          input logic [7:0] d, input logic [3:0] a,
                          input logic [7:0] exp_res, input logic exp_err,
                          input int hold);
        logic [7:0] m_r;
        logic       m_e;
        int         sh, offset, nshift;
        model(op, d, a, m_r, m_e, sh);

        @(negedge clk);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_amt = a;
        @(negedge clk);
        cmd_valid = 1'b0;
        offset = 1; nshift = 0;
        check({tag, "_load_s"}, 32'(sr_s), 32'd3);
        check({tag, "_load_i"}, 32'(sr_i), 32'(d));
        while (!res_valid && offset < 40) begin
            if (sr_s == 2'b01 || sr_s == 2'b10) nshift++;
            @(negedge clk);
            offset++;
        end
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_latency"}, 32'(offset), 32'(sh + 2));
        check({tag, "_steps"}, 32'(nshift), 32'(sh));
        check({tag, "_data"}, 32'(res_data), 32'(exp_res));
        check({tag, "_err"}, 32'(res_err), 32'(exp_err));
        check({tag, "_top_data"}, 32'({top_res_valid, top_res_err, top_res_data}),
              32'({1'b1, exp_err, exp_res}));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, 32'({res_valid, cmd_ready, busy, res_err, res_data}),
                  32'({1'b1, 1'b0, 1'b1, exp_err, exp_res}));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_drop"}, 32'({res_valid, cmd_ready, busy}), 32'b010);
    endtask

    initial begin
        logic [7:0] r;
        logic       e;
        int         sh;
        logic [2:0] op;
        logic [7:0] d;
        logic [3:0] a;

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        cmd_amt = '0; res_ready = 1'b0;
        #12;
        check("reset_outs",
              32'({cmd_ready, res_valid, res_err, busy, sr_s, sr_msb_in, sr_lsb_in}),
              32'b1000_0000);
        check("reset_sr_i", 32'(sr_i), 32'd0);
        @(negedge clk); reset_n = 1'b1;

        // Directed cases with hand-computed results.
        do_cmd("sll",  3'd0, 8'hB5, 4'd3,  8'hA8, 1'b0, 0);
        do_cmd("sra",  3'd2, 8'h96, 4'd2,  8'hE5, 1'b0, 0);
        do_cmd("srl",  3'd1, 8'h96, 4'd2,  8'h25, 1'b0, 1);
        do_cmd("ror",  3'd4, 8'h81, 4'd9,  8'hC0, 1'b0, 0);
        do_cmd("rol",  3'd3, 8'h81, 4'd1,  8'h03, 1'b0, 0);
        do_cmd("clamp",3'd1, 8'hFF, 4'd15, 8'h00, 1'b0, 0);
        do_cmd("sra8", 3'd2, 8'h80, 4'd12, 8'hFF, 1'b0, 0);
        do_cmd("amt0", 3'd3, 8'h5A, 4'd0,  8'h5A, 1'b0, 0);
        do_cmd("ill",  3'd7, 8'h5A, 4'd4,  8'h5A, 1'b1, 3);
        do_cmd("after_ill", 3'd0, 8'h01, 4'd8, 8'h00, 1'b0, 0);

        // Reset in the middle of a shift sequence.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_data = 8'hFF; cmd_amt = 4'd6;
        @(negedge clk); cmd_valid = 1'b0;   // LOAD
        @(negedge clk);                     // first SHIFT cycle
        @(negedge clk);                     // one step taken
        @(negedge clk);                     // two steps taken
        check("mid_sr_q", 32'(sr_q), 32'hFC);
        reset_n = 1'b0;
        #1;
        check("abort_outs", 32'({cmd_ready, res_valid, busy, sr_s}), 32'b10000);
        check("abort_sr_q", 32'({sr_q, top_reg_q}), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        do_cmd("post_rst", 3'd4, 8'h3C, 4'd2, 8'h0F, 1'b0, 0);

        // Randomized commands against the reference model.
        for (int k = 0; k < 24; k++) begin
            op = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            a  = 4'($urandom_range(0, 15));
            model(op, d, a, r, e, sh);
            do_cmd($sformatf("rnd%0d", k), op, d, a, r, e, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_shift_seq_ctrl
